// File: rtl/prog_loader_if.sv
// Byte-stream handshake feeding the instruction-memory loader.
// The source drives valid/data; the loader answers with ready.
interface prog_loader_if;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready;

    modport master (output byte_valid, output byte_data, input byte_ready);
    modport slave  (input byte_valid, input byte_data, output byte_ready);
endinterface

// File: rtl/prog_loader.sv
// Packs a little-endian byte stream into instruction words, writes them into the IM,
// then pulses the PC reset and holds the run enable.
module prog_loader #(
    parameter int WORD_WIDTH = 32,
    parameter int CNT_SIZE   = 7,
    parameter int RST_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [CNT_SIZE-1:0]   num_words,
    prog_loader_if.slave          bs,
    output logic                  ld_en,
    output logic [WORD_WIDTH-1:0] Load_data,
    output logic                  rst_counter,
    output logic                  rd_en,
    output logic [CNT_SIZE-1:0]   load_cnt,
    output logic                  done
);
    localparam int BYTES = WORD_WIDTH / 8;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int RC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, ASSEMBLE, WRITE, PC_RST, RUN} state_t;

    state_t                state, state_nxt;
    logic [IDX_W-1:0]      byte_idx;
    logic [WORD_WIDTH-1:0] word_q, word_nxt;
    logic [CNT_SIZE-1:0]   num_q, cnt_inc;
    logic [RC_W-1:0]       rst_cnt;
    logic                  accept, last_byte, rst_last;
    logic                  ld_en_d, rd_en_d, rst_counter_d, byte_ready_d;

    // byte_ready is a flop that mirrors ASSEMBLE, so this is a pure handshake qualifier
    assign accept    = bs.byte_valid & bs.byte_ready & ~abort;
    assign last_byte = (byte_idx == IDX_W'(BYTES - 1));
    assign rst_last  = (rst_cnt == RC_W'(RST_CYCLES - 1));
    assign cnt_inc   = load_cnt + 1'b1;

    always_comb begin
        word_nxt = word_q;
        word_nxt[{byte_idx, 3'b000} +: 8] = bs.byte_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start) state_nxt = (num_words == '0) ? PC_RST : ASSEMBLE;
            ASSEMBLE: if (accept && last_byte) state_nxt = WRITE;
            WRITE:    state_nxt = (cnt_inc == num_q) ? PC_RST : ASSEMBLE;
            PC_RST:   if (rst_last) state_nxt = RUN;
            RUN:      if (start) state_nxt = (num_words == '0) ? PC_RST : ASSEMBLE;
            default:  state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    // Strobes are decoded from the upcoming state so every output leaves a flop
    always_comb begin
        ld_en_d       = (state_nxt == WRITE);
        rd_en_d       = (state_nxt == RUN);
        byte_ready_d  = (state_nxt == ASSEMBLE);
        rst_counter_d = (state_nxt == IDLE) || (state_nxt == PC_RST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ld_en         <= 1'b0;
            rd_en         <= 1'b0;
            done          <= 1'b0;
            bs.byte_ready <= 1'b0;
            rst_counter   <= 1'b1;
        end else begin
            ld_en         <= ld_en_d;
            rd_en         <= rd_en_d;
            done          <= rd_en_d;
            bs.byte_ready <= byte_ready_d;
            rst_counter   <= rst_counter_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_idx  <= '0;
            word_q    <= '0;
            load_cnt  <= '0;
            num_q     <= '0;
            rst_cnt   <= '0;
            Load_data <= '0;
        end else begin
            rst_cnt <= (state == PC_RST) ? rst_cnt + 1'b1 : '0;
            if (state_nxt == WRITE) Load_data <= word_nxt;
            if (abort) begin
                byte_idx <= '0;
                word_q   <= '0;
                load_cnt <= '0;
            end else begin
                case (state)
                    IDLE, RUN: if (start) begin
                        num_q    <= num_words;
                        load_cnt <= '0;
                        byte_idx <= '0;
                        word_q   <= '0;
                    end
                    ASSEMBLE: if (accept) begin
                        word_q   <= word_nxt;
                        byte_idx <= last_byte ? '0 : byte_idx + 1'b1;
                    end
                    WRITE: begin
                        load_cnt <= cnt_inc;
                        byte_idx <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// Randomised bench for prog_loader: a word-level model of expected IM writes,
// PC-reset pulse widths and handshake invariants, for RST_CYCLES of 1 and 3.
module tb_prog_loader;
    localparam int WW = 32;
    localparam int CS = 7;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          start = 1'b0, abort = 1'b0;
    logic [CS-1:0] num_words = '0;
    logic          ld_en, rst_counter, rd_en, done;
    logic [WW-1:0] load_data;
    logic [CS-1:0] load_cnt;

    logic          start3 = 1'b0, abort3 = 1'b0;
    logic [CS-1:0] num3 = '0;
    logic          ld3, rc3, rd3, done3;
    logic [WW-1:0] ldata3;
    logic [CS-1:0] cnt3;

    prog_loader_if bs ();
    prog_loader_if bs3 ();

    prog_loader #(.WORD_WIDTH(WW), .CNT_SIZE(CS), .RST_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .num_words(num_words),
        .bs(bs), .ld_en(ld_en), .Load_data(load_data), .rst_counter(rst_counter),
        .rd_en(rd_en), .load_cnt(load_cnt), .done(done)
    );

    prog_loader #(.WORD_WIDTH(WW), .CNT_SIZE(CS), .RST_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .abort(abort3), .num_words(num3),
        .bs(bs3), .ld_en(ld3), .Load_data(ldata3), .rst_counter(rc3),
        .rd_en(rd3), .load_cnt(cnt3), .done(done3)
    );

    int checks = 0;
    int errors = 0;

    // Observed IM writes and handshake-rule violations, sampled mid-cycle
    logic [WW-1:0] wr_q[$];
    logic [WW-1:0] wr3_q[$];
    int            ld_cyc_q[$];
    int            cyc = 0, viol = 0, viol3 = 0, br_cycles = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            if (ld_en) begin
                wr_q.push_back(load_data);
                ld_cyc_q.push_back(cyc);
            end
            if ((ld_en && rd_en) || (ld_en && rst_counter) ||
                (bs.byte_ready && (ld_en || rd_en || rst_counter))) viol <= viol + 1;
            if (bs.byte_ready) br_cycles <= br_cycles + 1;
            if (ld3) wr3_q.push_back(ldata3);
            if ((ld3 && rd3) || (ld3 && rc3) ||
                (bs3.byte_ready && (ld3 || rd3 || rc3))) viol3 <= viol3 + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int n);
        num_words = CS'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input bit sel3, input logic [7:0] b);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        if (sel3) begin bs3.byte_valid = 1'b1; bs3.byte_data = b; end
        else      begin bs.byte_valid  = 1'b1; bs.byte_data  = b; end
        while (!acc && n < 40) begin
            @(negedge clk);
            acc = sel3 ? bs3.byte_ready : bs.byte_ready;
            tick();
            n++;
        end
        bs.byte_valid  = 1'b0;
        bs3.byte_valid = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL byte_accept: byte %h never accepted (byte_ready=0, required 1 within 40 cycles)", b);
        end
    endtask

    task automatic send_word(input bit sel3, input logic [WW-1:0] w, input int max_gap);
        for (int k = 0; k < WW / 8; k++) begin
            repeat ($urandom_range(0, max_gap)) tick();
            send_byte(sel3, w[8*k +: 8]);
        end
    endtask

    // Entered in the WRITE cycle of the last word (in_write) or directly in PC_RST
    task automatic finish_session(input bit sel3, input bit in_write, input int exp_rc,
                                  input int exp_cnt, input string tag);
        int rc, n;
        bit got;
        if (in_write) begin
            checks++;
            if ((sel3 ? ld3 : ld_en) !== 1'b1) begin
                errors++;
                $display("FAIL %s_ld_latency: ld_en=%b, required 1", tag, sel3 ? ld3 : ld_en);
            end
            tick();
        end
        rc = 0; n = 0; got = 1'b0;
        while (!got && n < 40) begin
            if ((sel3 ? rd3 : rd_en) === 1'b1) got = 1'b1;
            else begin
                if ((sel3 ? rc3 : rst_counter) === 1'b1) rc++;
                tick();
                n++;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s_run_timeout: rd_en=0 after 40 cycles, required 1", tag);
        end
        checks++;
        if (rc != exp_rc) begin
            errors++;
            $display("FAIL %s_pc_rst_width: rst_counter high %0d cycles, required %0d", tag, rc, exp_rc);
        end
        checks++;
        if ({(sel3 ? done3 : done), (sel3 ? rc3 : rst_counter), (sel3 ? cnt3 : load_cnt)} !==
            {1'b1, 1'b0, CS'(exp_cnt)}) begin
            errors++;
            $display("FAIL %s_run_state: done=%b rst_counter=%b load_cnt=%0d, required 1 0 %0d", tag,
                     sel3 ? done3 : done, sel3 ? rc3 : rst_counter, sel3 ? cnt3 : load_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++;
        if ({rst_counter, ld_en, rd_en, done, bs.byte_ready} !== 5'b10000 || load_cnt !== '0 || load_data !== '0) begin
            errors++;
            $display("FAIL reset_init: rc/ld/rd/done/rdy=%b load_cnt=%0d data=%h, required 10000 0 0",
                     {rst_counter, ld_en, rd_en, done, bs.byte_ready}, load_cnt, load_data);
        end
        rst = 1'b1;
        tick();
        pulse_start(1);
        send_byte(1'b0, 8'h29);
        send_byte(1'b0, 8'h09);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({rst_counter, ld_en, rd_en, done, bs.byte_ready} !== 5'b10000 || load_cnt !== '0) begin
            errors++;
            $display("FAIL reset_async: rc/ld/rd/done/rdy=%b load_cnt=%0d, required 10000 0",
                     {rst_counter, ld_en, rd_en, done, bs.byte_ready}, load_cnt);
        end
        tick();
        tick();
        checks++;
        if (rst_counter !== 1'b1 || ld_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: rst_counter=%b ld_en=%b, required 1 0", rst_counter, ld_en);
        end
        @(negedge clk) rst = 1'b1;
        tick();
        checks++;
        if ({rst_counter, bs.byte_ready} !== 2'b10) begin
            errors++;
            $display("FAIL reset_release_idle: rc/rdy=%b, required 10", {rst_counter, bs.byte_ready});
        end
    endtask

    task automatic test_single_word();
        wr_q.delete();
        pulse_start(1);
        send_byte(1'b0, 8'h29);
        send_byte(1'b0, 8'h09);
        send_byte(1'b0, 8'hA0);
        send_byte(1'b0, 8'h00);
        finish_session(1'b0, 1'b1, 1, 1, "single");
        checks++;
        if (wr_q.size() != 1 || wr_q[0] !== 32'h00A00929) begin
            errors++;
            $display("FAIL single_word: %0d writes, first %h, required 1 write of 00a00929",
                     wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : '0);
        end
    endtask

    task automatic test_back_to_back();
        logic [WW-1:0] w;
        ld_cyc_q.delete();
        pulse_start(3);
        for (int i = 0; i < 3; i++) begin
            w = $urandom();
            send_word(1'b0, w, 0);
        end
        finish_session(1'b0, 1'b1, 1, 3, "b2b");
        checks++;
        if (ld_cyc_q.size() != 3) begin
            errors++;
            $display("FAIL b2b_count: %0d ld_en pulses, required 3", ld_cyc_q.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (ld_cyc_q[i] - ld_cyc_q[i-1] != WW / 8 + 1) begin
                    errors++;
                    $display("FAIL b2b_spacing%0d: %0d cycles, required %0d", i,
                             ld_cyc_q[i] - ld_cyc_q[i-1], WW / 8 + 1);
                end
            end
        end
    endtask

    task automatic test_twelve_words();
        logic [WW-1:0] exp_q[$];
        exp_q = {32'h00A00929, 32'h005009A9};
        repeat (8) exp_q.push_back($urandom());
        exp_q.push_back(32'hFFFFE17B);
        exp_q.push_back(32'h00F00929);
        wr_q.delete();
        pulse_start(12);
        foreach (exp_q[i]) send_word(1'b0, exp_q[i], 2);
        finish_session(1'b0, 1'b1, 1, 12, "twelve");
        checks++;
        if (wr_q.size() != 12) begin
            errors++;
            $display("FAIL twelve_count: %0d writes, required 12", wr_q.size());
        end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= wr_q.size() || wr_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL twelve_word%0d: got %h, required %h", i,
                         (i < wr_q.size()) ? wr_q[i] : '0, exp_q[i]);
            end
        end
    endtask

    task automatic test_zero_length();
        int br0, n0;
        br0 = br_cycles;
        n0 = wr_q.size();
        bs.byte_valid = 1'b1;
        bs.byte_data = 8'h5A;
        pulse_start(0);
        finish_session(1'b0, 1'b0, 1, 0, "zero");
        bs.byte_valid = 1'b0;
        checks++;
        if (wr_q.size() != n0 || br_cycles != br0) begin
            errors++;
            $display("FAIL zero_no_load: writes %0d ready_cycles %0d, required 0 0",
                     wr_q.size() - n0, br_cycles - br0);
        end
    endtask

    task automatic test_abort();
        logic [WW-1:0] w0, w1, w2;
        w0 = $urandom(); w1 = $urandom(); w2 = $urandom();
        wr_q.delete();
        pulse_start(4);
        send_word(1'b0, w0, 1);
        send_word(1'b0, w1, 1);
        send_byte(1'b0, w2[7:0]);
        send_byte(1'b0, w2[15:8]);
        bs.byte_valid = 1'b1;
        bs.byte_data = 8'hEE;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        bs.byte_valid = 1'b0;
        checks++;
        if ({rst_counter, bs.byte_ready, ld_en, rd_en, done} !== 5'b10000 || load_cnt !== '0) begin
            errors++;
            $display("FAIL abort_idle: rc/rdy/ld/rd/done=%b load_cnt=%0d, required 10000 0",
                     {rst_counter, bs.byte_ready, ld_en, rd_en, done}, load_cnt);
        end
        checks++;
        if (wr_q.size() != 2 || wr_q[0] !== w0 || wr_q[1] !== w1) begin
            errors++;
            $display("FAIL abort_prior_writes: %0d writes, required 2 (%h %h)", wr_q.size(), w0, w1);
        end
        tick();
        wr_q.delete();
        pulse_start(1);
        send_byte(1'b0, 8'h81);
        send_byte(1'b0, 8'h8A);
        send_byte(1'b0, 8'h29);
        send_byte(1'b0, 8'h01);
        finish_session(1'b0, 1'b1, 1, 1, "abort_restart");
        checks++;
        if (wr_q.size() != 1 || wr_q[0] !== 32'h01298A81) begin
            errors++;
            $display("FAIL abort_restart_word: %0d writes, first %h, required 1 write of 01298a81",
                     wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : '0);
        end
    endtask

    task automatic test_reload();
        logic [WW-1:0] w0, w1;
        w0 = $urandom(); w1 = $urandom();
        wr_q.delete();
        pulse_start(2);
        checks++;
        if ({rd_en, done, bs.byte_ready} !== 3'b001) begin
            errors++;
            $display("FAIL reload_exit_run: rd/done/rdy=%b, required 001", {rd_en, done, bs.byte_ready});
        end
        send_byte(1'b0, w0[7:0]);
        send_byte(1'b0, w0[15:8]);
        pulse_start(5);
        send_byte(1'b0, w0[23:16]);
        send_byte(1'b0, w0[31:24]);
        pulse_start(7);
        checks++;
        if (load_cnt !== CS'(1) || bs.byte_ready !== 1'b1) begin
            errors++;
            $display("FAIL reload_ignored_start: load_cnt=%0d rdy=%b, required 1 1", load_cnt, bs.byte_ready);
        end
        send_word(1'b0, w1, 1);
        finish_session(1'b0, 1'b1, 1, 2, "reload");
        checks++;
        if (wr_q.size() != 2 || wr_q[0] !== w0 || wr_q[1] !== w1) begin
            errors++;
            $display("FAIL reload_words: %0d writes first %h, required 2 (%h %h)", wr_q.size(),
                     (wr_q.size() > 0) ? wr_q[0] : '0, w0, w1);
        end
    endtask

    task automatic test_rst_cycles3();
        logic [WW-1:0] a, b;
        a = $urandom(); b = $urandom();
        wr3_q.delete();
        num3 = CS'(2);
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        send_word(1'b1, a, 1);
        send_word(1'b1, b, 0);
        finish_session(1'b1, 1'b1, 3, 2, "rc3");
        checks++;
        if (wr3_q.size() != 2 || wr3_q[0] !== a || wr3_q[1] !== b) begin
            errors++;
            $display("FAIL rc3_words: %0d writes, required 2 (%h %h)", wr3_q.size(), a, b);
        end
    endtask

    task automatic test_invariants();
        @(negedge clk);
        checks++;
        if (viol != 0 || viol3 != 0) begin
            errors++;
            $display("FAIL strobe_exclusion: %0d/%0d overlapping-strobe cycles, required 0", viol, viol3);
        end
    endtask

    initial begin
        bs.byte_valid = 1'b0;  bs.byte_data = '0;
        bs3.byte_valid = 1'b0; bs3.byte_data = '0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_twelve_words();
        test_zero_length();
        test_abort();
        test_reload();
        test_rst_cycles3();
        test_invariants();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1);
    end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Upstream feeder for the processor's instruction memory load port.
- Accepts a byte stream over a valid/ready handshake and packs it little-endian into WORD_WIDTH-bit instructions.
- Drives ld_en/Load_data to write each packed word, then pulses rst_counter so the PC restarts at 0, then holds rd_en for execution.
- Replaces the hand-sequenced ld_en/rd_en/rst_counter stimulus with a self-timed hardware loader.

Parameters:
- WORD_WIDTH, 32, instruction width; must be a multiple of 8.
- CNT_SIZE, 7, width of the word counter and num_words (IM depth 2^CNT_SIZE).
- RST_CYCLES, 1, number of cycles rst_counter is held high between load and run (>=1).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load session; honoured only in IDLE or RUN.
- abort  in  1  returns the FSM to IDLE from any state; discards any partial word.
- num_words  in  CNT_SIZE  number of words to load; sampled on the start cycle.
- byte_valid  in  1  byte_data is valid.
- byte_data  in  8  stream byte, least-significant byte of each word first.
- byte_ready  out  1  loader can accept a byte.
- ld_en  out  1  instruction-memory write strobe.
- Load_data  out  WORD_WIDTH  instruction word to write.
- rst_counter  out  1  program counter reset.
- rd_en  out  1  instruction-memory read / run enable.
- load_cnt  out  CNT_SIZE  words written in the current session.
- done  out  1  high while in RUN.

Behaviour:
- States: IDLE, ASSEMBLE, WRITE, PC_RST, RUN.
- Reset (rst=0, async) forces:
  - state=IDLE, byte index=0, word register=0, load_cnt=0
  - ld_en=0, rd_en=0, done=0, byte_ready=0, Load_data=0
  - rst_counter=1
- IDLE:
  - rst_counter=1; all other strobes 0.
  - start: latch num_words, clear load_cnt and byte index.
  - If num_words==0, go to PC_RST; otherwise go to ASSEMBLE.
- ASSEMBLE:
  - byte_ready=1, rst_counter=0.
  - A byte is accepted only on a cycle where byte_valid & byte_ready.
  - Byte k (k=0..WORD_WIDTH/8-1) is placed in bits [8k+7:8k].
  - Acceptance of the last byte moves the FSM to WRITE on the next edge.
  - Idle cycles (byte_valid=0) leave the state and index unchanged.
- WRITE:
  - Exactly one cycle: ld_en=1, Load_data=assembled word, byte_ready=0.
  - load_cnt increments at the end of the cycle and byte index returns to 0.
  - If incremented load_cnt == num_words, go to PC_RST; otherwise return to ASSEMBLE.
- Load_data:
  - Registered; holds the last written word outside WRITE.
  - Value is only meaningful when ld_en=1.
- PC_RST:
  - rst_counter=1, ld_en=0, rd_en=0, byte_ready=0, for RST_CYCLES cycles (internal counter).
  - Then go to RUN.
- RUN:
  - rd_en=1, done=1, rst_counter=0, byte_ready=0.
  - Stays in RUN until start or abort.
  - start: rd_en and done drop on the next edge; relatch num_words; go to ASSEMBLE, or PC_RST if num_words==0.
- abort:
  - Has priority over start and over byte acceptance in the same cycle.
  - Next state is IDLE; partial word is discarded; load_cnt is cleared.
  - Memory contents already written are not undone.
- start outside IDLE/RUN is ignored; it does not restart the session.
- ld_en and rd_en are never high in the same cycle. ld_en and rst_counter are never high in the same cycle.
- Latency: last byte accepted at edge N produces ld_en=1 in cycle N+1. Final WRITE is followed immediately by PC_RST.
- Minimum spacing between ld_en pulses is WORD_WIDTH/8+1 cycles.
- load_cnt wraps modulo 2^CNT_SIZE; num_words = 2^CNT_SIZE-1 is the maximum session length.
- All outputs are registered; no combinational path from byte_valid to byte_ready.

Test Plan:
- Reset then single word:
  - Stimulus: rst low mid-ASSEMBLE; release; start with num_words=1; bytes 29,09,A0,00 back-to-back.
  - Required: rst_counter=1 and ld_en=0 during reset; one ld_en pulse with Load_data=32'h00A00929; load_cnt=1; rst_counter high 1 cycle; then rd_en=1, done=1.
- Twelve-word program:
  - Stimulus: num_words=12; bytes with random byte_valid gaps; words 00A00929, 005009A9, … FFFFE17B, 00F00929.
  - Required: 12 ld_en pulses, in order, with exact values; byte_ready never high during WRITE/PC_RST/RUN; no byte dropped or duplicated.
- Zero-length session:
  - Stimulus: start with num_words=0.
  - Required: no ld_en; byte_ready never asserts; rst_counter pulse then rd_en=1.
- Abort mid-word:
  - Stimulus: abort after 2 bytes of word 3; then start with num_words=1; bytes 81,8A,29,01.
  - Required: IDLE with load_cnt=0; next write is Load_data=32'h01298A81 (no stale bytes).
- Reload from RUN and ignored start:
  - Stimulus: start pulse in RUN; start pulse again during ASSEMBLE.
  - Required: rd_en falls next edge; the second start does not reset byte index or load_cnt.
- RST_CYCLES=3 build:
  - Required: rst_counter high exactly 3 cycles between final ld_en and rd_en rising.
